// File: rtl/segment_chase_pkg.sv
// Shared types and constants for the seven-segment chase decoder.
//   chase_state_e      : tracking FSM states
//   POS_TO_SEG         : figure-eight position (0..7) to segment index (0..6 = a..g)
//   seg_to_unique_pos  : inverse lookup for every segment except g, which has two positions
package segment_chase_pkg;

  localparam int unsigned NUM_SEGS = 7;
  localparam int unsigned SEG_W    = 3;
  localparam int unsigned POS_W    = 3;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } chase_state_e;

  localparam logic [SEG_W-1:0] SEG_A = 3'd0;
  localparam logic [SEG_W-1:0] SEG_B = 3'd1;
  localparam logic [SEG_W-1:0] SEG_C = 3'd2;
  localparam logic [SEG_W-1:0] SEG_D = 3'd3;
  localparam logic [SEG_W-1:0] SEG_E = 3'd4;
  localparam logic [SEG_W-1:0] SEG_F = 3'd5;
  localparam logic [SEG_W-1:0] SEG_G = 3'd6;

  // Element 0 is the rightmost entry: a, b, g, e, d, c, g, f
  localparam logic [7:0][SEG_W-1:0] POS_TO_SEG =
    {SEG_F, SEG_G, SEG_C, SEG_D, SEG_E, SEG_G, SEG_B, SEG_A};

  // Segment g maps to both 2 and 6; callers must not rely on its result
  function automatic logic [POS_W-1:0] seg_to_unique_pos(input logic [SEG_W-1:0] seg);
    logic [POS_W-1:0] pos;
    case (seg)
      SEG_A:   pos = 3'd0;
      SEG_B:   pos = 3'd1;
      SEG_E:   pos = 3'd3;
      SEG_D:   pos = 3'd4;
      SEG_C:   pos = 3'd5;
      SEG_F:   pos = 3'd7;
      default: pos = 3'd2;
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/seg_duty_meter.sv
// Per-segment duty meter: 2-flop synchroniser, polarity fix, on-count over one
// window and a registered "bright" flag (duty strictly above half the window).
//   clk, reset   : clock, synchronous active-high reset
//   i_seg        : raw segment line
//   i_win_start  : first cycle of a window (count restarts from this sample)
//   i_win_end    : last cycle of a window (final sample folded into o_bright)
//   o_bright     : registered, valid from the cycle after i_win_end
module seg_duty_meter
  import segment_chase_pkg::*;
#(
  parameter int unsigned WINDOW_WIDTH = 8,
  parameter bit          COMMON_ANODE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_seg,
  input  logic i_win_start,
  input  logic i_win_end,
  output logic o_bright
);

  localparam int unsigned      CNT_W = WINDOW_WIDTH + 1;
  localparam logic [CNT_W-1:0] HALF  = CNT_W'(2 ** (WINDOW_WIDTH - 1));

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             w_on;
  logic [CNT_W-1:0] w_sum;

  assign w_on  = r_sync[1] ^ COMMON_ANODE;
  assign w_sum = r_cnt + CNT_W'(w_on);

  // Synchroniser resets to the idle (unlit) level so the first window is unbiased
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync   <= {2{COMMON_ANODE}};
      r_cnt    <= '0;
      o_bright <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_seg};
      if (i_win_start) r_cnt <= CNT_W'(w_on);
      else             r_cnt <= w_sum;
      if (i_win_end)   o_bright <= (w_sum > HALF);
    end
  end

endmodule

// File: rtl/segment_chase_decoder.sv
// Receive-side decoder for the seven-segment chase: finds the single fully-lit
// head segment per duty window and tracks it along the figure-eight sequence.
//   clk, reset   : clock, synchronous active-high reset
//   seg_in[6:0]  : raw segment lines a..g
//   position     : current chase position 0..7
//   direction    : 1 = incrementing, 0 = decrementing
//   locked       : high while in LOCKED
//   step_valid   : one-cycle pulse per confirmed step
//   seq_error    : one-cycle pulse on an out-of-sequence head while LOCKED
//   step_period  : cycles between the last two confirmed steps
// Build option SEGCHASE_PERIOD_EN: enables the step-period counter; otherwise
// step_period is tied to zero.
module segment_chase_decoder
  import segment_chase_pkg::*;
#(
  parameter int unsigned WINDOW_WIDTH    = 8,
  parameter bit          COMMON_ANODE    = 1'b1,
  parameter int unsigned PERIOD_WIDTH    = 24,
  parameter int unsigned TIMEOUT_WINDOWS = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_SEGS-1:0]     seg_in,
  output logic [POS_W-1:0]        position,
  output logic                    direction,
  output logic                    locked,
  output logic                    step_valid,
  output logic                    seq_error,
  output logic [PERIOD_WIDTH-1:0] step_period
);

  localparam int unsigned DARK_W = $clog2(TIMEOUT_WINDOWS + 1);

  logic [WINDOW_WIDTH-1:0] r_win_cnt;
  logic                    r_eval;
  logic [DARK_W-1:0]       r_dark;
  chase_state_e            r_state;

  logic                    w_win_start;
  logic                    w_win_end;
  logic [NUM_SEGS-1:0]     w_bright;
  logic [SEG_W-1:0]        w_bright_cnt;
  logic [SEG_W-1:0]        w_head;
  logic                    w_valid;
  logic                    w_dark;
  logic                    w_timeout;
  logic [POS_W-1:0]        w_pos_inc;
  logic [POS_W-1:0]        w_pos_dec;
  logic                    w_hold;
  logic                    w_fwd;
  logic                    w_bwd;
  logic                    w_step_evt;

  // Free-running window counter; r_eval marks the cycle the bright flags are fresh
  assign w_win_start = (r_win_cnt == '0);
  assign w_win_end   = &r_win_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_cnt <= '0;
      r_eval    <= 1'b0;
    end else begin
      r_win_cnt <= r_win_cnt + WINDOW_WIDTH'(1);
      r_eval    <= w_win_end;
    end
  end

  for (genvar g = 0; g < NUM_SEGS; g++) begin : g_meter
    seg_duty_meter #(
      .WINDOW_WIDTH (WINDOW_WIDTH),
      .COMMON_ANODE (COMMON_ANODE)
    ) u_meter (
      .clk         (clk),
      .reset       (reset),
      .i_seg       (seg_in[g]),
      .i_win_start (w_win_start),
      .i_win_end   (w_win_end),
      .o_bright    (w_bright[g])
    );
  end

  // Head classification: count bright segments and remember the (last) bright index
  always_comb begin
    w_bright_cnt = '0;
    w_head       = '0;
    for (int i = 0; i < NUM_SEGS; i++) begin
      if (w_bright[i]) begin
        w_bright_cnt = w_bright_cnt + SEG_W'(1);
        w_head       = SEG_W'(i);
      end
    end
  end

  assign w_valid   = r_eval && (w_bright_cnt == SEG_W'(1));
  assign w_dark    = r_eval && (w_bright_cnt == '0);
  assign w_timeout = w_dark && (r_dark == DARK_W'(TIMEOUT_WINDOWS - 1));

  // Neighbour matching against the table also resolves segment g by predecessor
  assign w_pos_inc  = position + POS_W'(1);
  assign w_pos_dec  = position - POS_W'(1);
  assign w_hold     = (w_head == POS_TO_SEG[position]);
  assign w_fwd      = (w_head == POS_TO_SEG[w_pos_inc]);
  assign w_bwd      = (w_head == POS_TO_SEG[w_pos_dec]);
  assign w_step_evt = w_valid && (r_state == ST_LOCKED) && !w_hold &&
                      (direction ? w_fwd : w_bwd);

  // Tracking FSM; two-bright (transition) windows fall through and hold everything
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_UNLOCKED;
      r_dark     <= '0;
      position   <= '0;
      direction  <= 1'b0;
      locked     <= 1'b0;
      step_valid <= 1'b0;
      seq_error  <= 1'b0;
    end else begin
      step_valid <= 1'b0;
      seq_error  <= 1'b0;
      if (w_dark) begin
        if (w_timeout) begin
          r_dark  <= '0;
          r_state <= ST_UNLOCKED;
          locked  <= 1'b0;
        end else begin
          r_dark <= r_dark + DARK_W'(1);
        end
      end else if (w_valid) begin
        r_dark <= '0;
        case (r_state)
          ST_UNLOCKED: begin
            if (w_head != SEG_G) begin
              position <= seg_to_unique_pos(w_head);
              r_state  <= ST_ACQUIRE;
            end
          end
          ST_ACQUIRE: begin
            if (!w_hold) begin
              if (w_fwd) begin
                position  <= w_pos_inc;
                direction <= 1'b1;
                r_state   <= ST_LOCKED;
                locked    <= 1'b1;
              end else if (w_bwd) begin
                position  <= w_pos_dec;
                direction <= 1'b0;
                r_state   <= ST_LOCKED;
                locked    <= 1'b1;
              end else begin
                r_state <= ST_UNLOCKED;
              end
            end
          end
          ST_LOCKED: begin
            if (!w_hold) begin
              if (w_step_evt) begin
                position   <= direction ? w_pos_inc : w_pos_dec;
                step_valid <= 1'b1;
              end else begin
                seq_error <= 1'b1;
                r_state   <= ST_UNLOCKED;
                locked    <= 1'b0;
              end
            end
          end
          default: begin
            r_state <= ST_UNLOCKED;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SEGCHASE_PERIOD_EN
  logic [PERIOD_WIDTH-1:0] r_per_cnt;
  logic [PERIOD_WIDTH-1:0] w_per_inc;
  logic                    w_lock_evt;

  assign w_lock_evt = w_valid && (r_state == ST_ACQUIRE) && !w_hold && (w_fwd || w_bwd);
  assign w_per_inc  = (&r_per_cnt) ? r_per_cnt : r_per_cnt + PERIOD_WIDTH'(1);

  // Lock restarts the measurement without latching; each step latches and restarts
  always_ff @(posedge clk) begin
    if (reset) begin
      r_per_cnt   <= '0;
      step_period <= '0;
    end else if (w_step_evt) begin
      step_period <= w_per_inc;
      r_per_cnt   <= '0;
    end else if (w_lock_evt) begin
      r_per_cnt <= '0;
    end else begin
      r_per_cnt <= w_per_inc;
    end
  end
`else
  assign step_period = '0;
`endif

endmodule

// File: doc/segment_chase_decoder.md
# segment_chase_decoder

Receive-side counterpart of the TinyTapeout seven-segment chase driver. It samples the seven PWM-faded segment lines and measures per-segment duty over fixed windows to find the single fully-lit "head" segment. It then tracks the head along the figure-eight sequence and reports the current position, chase direction, lock status and, optionally, the step period. It sits on the board-level loopback and test harness, reading another tile's segment outputs.

## Interface
- WINDOW_WIDTH, 8: duty window is 2^WINDOW_WIDTH cycles; must be an integer multiple of the driver PWM period (128 cycles).
- COMMON_ANODE, 1: 1 = segment lines active-low, inverted after synchronisation.
- PERIOD_WIDTH, 24: width of the step-period counter.
- TIMEOUT_WINDOWS, 16: consecutive windows with no lit segment before lock is dropped.

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- seg_in  in  7  raw segment lines, index 0..6 = a..g
- position  out  3  current chase position 0..7; reset 0
- direction  out  1  1 = position incrementing, 0 = decrementing; reset 0
- locked  out  1  high in LOCKED state; reset 0
- step_valid  out  1  one-cycle pulse on each confirmed step; reset 0
- seq_error  out  1  one-cycle pulse on an out-of-sequence head while LOCKED; reset 0
- step_period  out  PERIOD_WIDTH  cycles between the last two confirmed steps; reset 0

## Operation
- Input: 2-flop synchroniser per line, then an XOR with COMMON_ANODE gives active-high `on`.
- Duty meter: free-running window counter. Each segment has an on-count of WINDOW_WIDTH+1 bits, cleared at window start. A segment is "bright" when its count > 2^(WINDOW_WIDTH-1), i.e. duty > 50%.
- Head classification per window:
  - exactly one bright segment: valid head.
  - zero bright segments: dark window.
  - two or more bright segments: transition window. Ignored; holds all state and does not count toward timeout.
- Sequence table (position to segment): 0:0, 1:1, 2:6, 3:4, 4:3, 5:2, 6:6, 7:5.
- FSM states: UNLOCKED, ACQUIRE, LOCKED.
  - UNLOCKED: a valid head other than segment 6 sets position to its unique table index and moves to ACQUIRE. A segment-6 head is ambiguous and ignored.
  - ACQUIRE: a head equal to the current position's segment is held.
    - Head matches position+1 (mod 8): direction=1, move to LOCKED.
    - Head matches position−1 (mod 8): direction=0, move to LOCKED.
    - Any other head: back to UNLOCKED.
  - LOCKED: a head equal to the current position's segment is held. A head matching position±1 in the current direction advances position and pulses step_valid. Any other head pulses seq_error and moves to UNLOCKED.
- Segment-6 disambiguation uses the predecessor position: from 1 or 3 the next position is 2; from 5 or 7 it is 6.
- A direction reversal while LOCKED is treated as a sequence error; relock occurs via ACQUIRE.
- Dark-window counter: increments on dark windows and clears on valid heads. When it reaches TIMEOUT_WINDOWS, the FSM goes to UNLOCKED with no seq_error.
- reset mid-operation clears everything, including window and duty counters, on the next edge.

## Timing
- seg_in to duty counters: 2 cycles of synchroniser latency.
- Cycle W (window counter at max): final sample accumulated, window closes.
- Cycle W+1: head classification registered; duty counters restart from this cycle's sample.
- Cycle W+2: position, direction, locked, step_valid, seq_error and step_period update.
- step_valid and seq_error are never high in the same cycle.
- step_period counter saturates at all-ones. It is latched and cleared on each step_valid; the first step after ACQUIRE does not latch.

## Configuration
- SEGCHASE_PERIOD_EN:
  - Defined: step-period counter and step_period output are active as described.
  - Undefined: counter removed, step_period tied to 0, all other behaviour identical.

## Structure
- Package segment_chase_pkg holds:
  - FSM state enum.
  - 8-entry position-to-segment table constant.
  - Segment index constants.
- Sub-module seg_duty_meter is instantiated 7 times: synchroniser, inversion, on-counter and bright flag, with window start/end supplied by the parent.

## Test plan
- After reset, seg_in all 1 (COMMON_ANODE) for 20 windows: position=0, locked=0, no pulses.
- Driver model steps 0→1→2 forward every 16 windows, head at 31/32 duty and tails ≤15/32: locked=1 after the 0→1 step; step_valid pulses at step 1→2 and later steps; direction=1.
- Backward chase 7→6→5: ACQUIRE locks with direction=0; a segment-6 head resolves to position 6, not 2.
- While LOCKED at position 3, force head to segment 0: seq_error pulses once, locked=0 at W+2.
- Stop driving (all dark) for 16 windows: locked drops at the 16th dark window with no seq_error; a transition window with two bright segments does not advance the timeout.
- SEGCHASE_PERIOD_EN defined, steps every 4096 cycles: step_period=4096 (±window quantisation of 256) from the second step onward.
